cla_adder_datapath: RTL and testbench

Datapath responder for the carry-lookahead adder controller. It consumes the controller's load_a/load_b/clear_a/clear_b/done strobes, captures operands from a shared input bus into A/B registers, and on done computes A+B through a grouped carry-lookahead network. Sum, carry-out, signed overflow and status flags are registered and handed to the consumer. It sits beside the controller inside the adder top level, fed by the same clock.

---
 rtl/cla_adder_datapath_pkg.sv | 10 +
 rtl/cla_adder_datapath_group4.sv | 30 +++
 rtl/cla_adder_datapath.sv | 138 +++++++++++++
 tb/tb_cla_adder_datapath.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cla_adder_datapath_pkg.sv
// Shared constants for the carry-lookahead adder datapath.
package cla_adder_datapath_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_groups(input int n);
        return n / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_adder_datapath_group4.sv
// 4-bit lookahead group: internal carries from cin, plus group P/G for the second level.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       p,
    output logic       g
);

    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    assign pb = a ^ b;
    assign gb = a & b;

    // Flat two-level carries; no ripple inside the group either.
    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign s = pb ^ c;
    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/cla_adder_datapath.sv
// Operand registers, grouped CLA and registered result/status for the adder controller.
module cla_adder_datapath
    import cla_adder_datapath_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    input  logic         load_a,
    input  logic         load_b,
    input  logic         clear_a,
    input  logic         clear_b,
    input  logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         a_valid,
    output logic         b_valid,
    output logic         sum_valid,
    output logic         seq_err
);

    localparam int NG = num_groups(N);

    logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          av_q, av_d, bv_q, bv_d;
    logic          cout_q, cout_d, ovf_q, ovf_d, sv_q, sv_d, err_q, err_d;
    logic [N-1:0]  sum_raw;
    logic [NG-1:0] gp, gg;
    logic [NG:0]   gc;
    logic          ovf_raw, any_strobe;

    // Each group carry is an independent sum of products of group P/G (cin = 0).
    function automatic logic [NG:0] lookahead(input logic [NG-1:0] g_in,
                                              input logic [NG-1:0] p_in);
        logic [NG:0] c;
        logic        t;
        c = '0;
        for (int j = 1; j <= NG; j++) begin
            for (int k = 0; k < j; k++) begin
                t = g_in[k];
                for (int m = k + 1; m < j; m++) t = t & p_in[m];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

    cla_group4 u_grp [NG-1:0] (
        .a   (a_q),
        .b   (b_q),
        .cin (gc[NG-1:0]),
        .s   (sum_raw),
        .p   (gp),
        .g   (gg)
    );

    assign gc      = lookahead(gg, gp);
    assign ovf_raw = (a_q[N-1] == b_q[N-1]) && (sum_raw[N-1] != a_q[N-1]);
    assign any_strobe = load_a | load_b | clear_a | clear_b;

    always_comb begin
        a_d    = a_q;
        av_d   = av_q;
        b_d    = b_q;
        bv_d   = bv_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        sv_d   = sv_q;
        err_d  = err_q;

        if (clear_a) begin
            a_d  = '0;
            av_d = 1'b0;
        end else if (load_a) begin
            a_d  = data_in;
            av_d = 1'b1;
        end

        if (clear_b) begin
            b_d  = '0;
            bv_d = 1'b0;
        end else if (load_b) begin
            b_d  = data_in;
            bv_d = 1'b1;
        end

        // Any operand change stales the result, even if done arrives on the same edge.
        if (any_strobe) begin
            sv_d = 1'b0;
        end else if (done && av_q && bv_q) begin
            sum_d  = sum_raw;
            cout_d = gc[NG];
            ovf_d  = ovf_raw;
            sv_d   = 1'b1;
        end

        if (clear_a && clear_b)
            err_d = 1'b0;
        else if (done && !(av_q && bv_q))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            av_q   <= 1'b0;
            bv_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            sv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            av_q   <= av_d;
            bv_q   <= bv_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            sv_q   <= sv_d;
            err_q  <= err_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign a_valid   = av_q;
    assign b_valid   = bv_q;
    assign sum_valid = sv_q;
    assign seq_err   = err_q;

endmodule

// File: tb/tb_cla_adder_datapath.sv
// Directed checks of operand capture, CLA results, invalidate priority and seq_err.
module tb_cla_adder_datapath;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic         load_a, load_b, clear_a, clear_b, done;
    logic [N-1:0] sum;
    logic         cout, overflow, a_valid, b_valid, sum_valid, seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    cla_adder_datapath #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .load_a    (load_a),
        .load_b    (load_b),
        .clear_a   (clear_a),
        .clear_b   (clear_b),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .sum_valid (sum_valid),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive strobes, take one rising edge, settle 1 time unit, then drop the strobes.
    task automatic cyc(input logic [N-1:0] d, input logic la, input logic lb,
                       input logic ca, input logic cb, input logic dn);
        data_in = d; load_a = la; load_b = lb; clear_a = ca; clear_b = cb; done = dn;
        @(posedge clk);
        #1;
        load_a = 0; load_b = 0; clear_a = 0; clear_b = 0; done = 0;
    endtask

    task automatic check_res(input string tag, input logic [N-1:0] s, input logic c,
                             input logic o, input logic sv);
        check({tag, ".sum"}, 32'(sum), 32'(s));
        check({tag, ".cout"}, 32'(cout), 32'(c));
        check({tag, ".ovf"}, 32'(overflow), 32'(o));
        check({tag, ".sum_valid"}, 32'(sum_valid), 32'(sv));
    endtask

    // Load A then B on separate edges, then request the sum.
    task automatic add(input logic [N-1:0] a, input logic [N-1:0] b);
        cyc(a, 1, 0, 0, 0, 0);
        cyc(b, 0, 1, 0, 0, 0);
        cyc('0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b1;
        data_in = '0; load_a = 0; load_b = 0; clear_a = 0; clear_b = 0; done = 0;

        // Asynchronous reset mid-cycle with an operand just loaded
        cyc(16'hDEAD, 1, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_res("reset", 16'h0000, 0, 0, 0);
        check("reset.a_valid", 32'(a_valid), 0);
        check("reset.b_valid", 32'(b_valid), 0);
        check("reset.seq_err", 32'(seq_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal
        cyc(16'h1234, 1, 0, 0, 0, 0);
        check("nom.a_valid", 32'(a_valid), 1);
        check("nom.b_valid0", 32'(b_valid), 0);
        cyc(16'h4321, 0, 1, 0, 0, 0);
        check("nom.b_valid", 32'(b_valid), 1);
        check("nom.sv0", 32'(sum_valid), 0);
        cyc('0, 0, 0, 0, 0, 1);
        check_res("nom", 16'h5555, 0, 0, 1);
        cyc('0, 0, 0, 0, 0, 1);
        check_res("hold_done", 16'h5555, 0, 0, 1);

        // A strobe stales the result but the sum holds
        cyc(16'hFFFF, 1, 0, 0, 0, 0);
        check_res("stale", 16'h5555, 0, 0, 0);
        cyc(16'h0001, 0, 1, 0, 0, 0);
        cyc('0, 0, 0, 0, 0, 1);
        check_res("wrap", 16'h0000, 1, 0, 1);

        add(16'h7FFF, 16'h0001);
        check_res("ovf_pos", 16'h8000, 0, 1, 1);
        add(16'h8000, 16'h8000);
        check_res("ovf_neg", 16'h0000, 1, 1, 1);
        add(16'hA5A5, 16'h5A5B);
        check_res("chain", 16'h0000, 1, 0, 1);
        add(16'h0FFF, 16'h0001);
        check_res("grp_carry", 16'h1000, 0, 0, 1);
        add(16'h6000, 16'h3000);
        check_res("ovf_pos2", 16'h9000, 0, 1, 1);

        // Both loads on one edge capture the same value
        cyc(16'h0102, 1, 1, 0, 0, 0);
        cyc('0, 0, 0, 0, 0, 1);
        check_res("dual_load", 16'h0204, 0, 0, 1);

        // Missing operand
        cyc('0, 0, 0, 1, 1, 0);
        check("clr.a_valid", 32'(a_valid), 0);
        check("clr.b_valid", 32'(b_valid), 0);
        check("clr.sv", 32'(sum_valid), 0);
        cyc(16'h00AA, 1, 0, 0, 0, 0);
        cyc('0, 0, 0, 0, 0, 1);
        check("miss.seq_err", 32'(seq_err), 1);
        check("miss.sv", 32'(sum_valid), 0);
        check("miss.sum", 32'(sum), 32'h0204);
        cyc('0, 0, 0, 1, 0, 0);
        check("err_sticky", 32'(seq_err), 1);
        cyc('0, 0, 0, 1, 1, 0);
        check("err_clr", 32'(seq_err), 0);
        check("err_clr.a_valid", 32'(a_valid), 0);

        // Clear beats load and invalidate beats done
        add(16'h1111, 16'h2222);
        check_res("pre_prio", 16'h3333, 0, 0, 1);
        cyc(16'hFFFF, 1, 0, 1, 0, 1);
        check("prio.a_valid", 32'(a_valid), 0);
        check("prio.b_valid", 32'(b_valid), 1);
        check_res("prio", 16'h3333, 0, 0, 0);
        check("prio.seq_err", 32'(seq_err), 0);
        cyc('0, 0, 0, 0, 0, 1);
        check("prio_done.seq_err", 32'(seq_err), 1);
        check("prio_done.sv", 32'(sum_valid), 0);
        cyc(16'h0005, 1, 0, 0, 0, 0);
        cyc('0, 0, 0, 0, 0, 1);
        check_res("post_prio", 16'h2227, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
